// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 5-8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Majority-votes three samples around mid-bit and reports each frame with a one-cycle strobe.
module uart_rx_os #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_tick,
    input  logic       rx,
    input  logic [1:0] data_len,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       stop2,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line;
    logic [TW-1:0]          t_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_q;
    logic                   s0_q, s1_q;
    logic                   vote;
    logic [1:0]             cfg_len;
    logic                   cfg_par, cfg_odd, cfg_stop2;
    logic                   par_pend, frm_pend;

    logic at_dec, last_data, last_stop;
    logic start_det, shift_en, par_chk, stop_chk, finish;

    // NOTE: the synchroniser resets to 1 so the idle-high line is not mistaken for a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign line = sync_q[SYNC_STAGES-1];

    assign vote      = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);
    assign at_dec    = rx_tick && (t_cnt == T_DEC);
    assign last_data = (bit_cnt == (3'd4 + {1'b0, cfg_len}));
    assign last_stop = !cfg_stop2 || bit_cnt[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_chk  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_tick && !line) begin
                    state_d   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (at_dec) state_d = vote ? IDLE : DATA;
            end
            DATA: begin
                if (at_dec) begin
                    shift_en = 1'b1;
                    if (last_data) state_d = cfg_par ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_dec) begin
                    par_chk = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_dec) begin
                    stop_chk = 1'b1;
                    if (last_stop) begin
                        finish  = 1'b1;
                        state_d = vote ? IDLE : BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_tick && line) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter free-runs through a frame; continuing past the start decision
    // places every later decision exactly one bit period on, mid-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_cnt <= '0;
            s0_q  <= 1'b1;
            s1_q  <= 1'b1;
        end else if (start_det) begin
            t_cnt <= '0;
        end else if (rx_tick && state != IDLE && state != BREAK) begin
            t_cnt <= (t_cnt == T_LAST) ? '0 : t_cnt + TW'(1);
            if (t_cnt == T_S0) s0_q <= line;
            if (t_cnt == T_S1) s1_q <= line;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            cfg_len   <= '0;
            cfg_par   <= 1'b0;
            cfg_odd   <= 1'b0;
            cfg_stop2 <= 1'b0;
            par_pend  <= 1'b0;
            frm_pend  <= 1'b0;
        end else if (start_det) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            cfg_len   <= data_len;
            cfg_par   <= parity_en;
            cfg_odd   <= parity_odd;
            cfg_stop2 <= stop2;
            par_pend  <= 1'b0;
            frm_pend  <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_q[bit_cnt] <= vote;
                bit_cnt          <= last_data ? 3'd0 : bit_cnt + 3'd1;
            end
            // Unreceived high bits are still 0, so reducing all 8 bits is safe.
            if (par_chk && (vote != ((^shift_q) ^ cfg_odd))) par_pend <= 1'b1;
            if (stop_chk) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (!vote) frm_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done <= finish;
            if (finish) begin
                rx_data    <= shift_q;
                parity_err <= par_pend;
                frame_err  <= frm_pend | !vote;
            end
        end
    end

    assign busy = (state == DATA) || (state == PARITY) || (state == STOP);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: frames are built bit by bit from their
// fields, and the expected word and flags are queued and checked every cycle.
module tb_uart_rx_os;

    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_tick;
    logic       rx;
    logic [1:0] data_len;
    logic       parity_en, parity_odd, stop2;
    logic [7:0] rx_data;
    logic       rx_done, parity_err, frame_err, busy;

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    int   n_done = 0;
    logic busy_hit = 1'b0;
    exp_t exp_q[$];
    exp_t cur;

    uart_rx_os #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_tick    (rx_tick),
        .rx         (rx),
        .data_len   (data_len),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Outputs are checked every cycle against the last frame the model expects delivered.
    always @(negedge clk) begin
        if (!rst) begin
            cur = '0;
        end else if (rx_done) begin
            n_done++;
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
        end
        if (busy) busy_hit = 1'b1;
        check("rx_data", 32'(rx_data), 32'(cur.data));
        check("parity_err", 32'(parity_err), 32'(cur.perr));
        check("frame_err", 32'(frame_err), 32'(cur.ferr));
    end

    // One tick period per call iteration; the line settles through the synchroniser before the tick.
    task automatic run_ticks(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            rx = lvl;
            repeat (3) @(posedge clk);
            #1 rx_tick = 1'b1;
            @(posedge clk);
            #1 rx_tick = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [1:0] len, input logic pen, input logic podd,
                              input logic s2, input logic [7:0] d, input logic bad_par,
                              input logic [1:0] bad_stop);
        int         nb;
        logic [7:0] dm;
        exp_t       e;
        nb     = 5 + int'(len);
        dm     = d & 8'((1 << nb) - 1);
        e.data = dm;
        e.perr = pen & bad_par;
        e.ferr = bad_stop[0] | (s2 & bad_stop[1]);
        exp_q.push_back(e);
        n_push++;
        data_len   = len;
        parity_en  = pen;
        parity_odd = podd;
        stop2      = s2;
        run_ticks(1'b0, OS);
        // Settings are latched at start detect; scrambling them now must not matter.
        data_len   = 2'($urandom);
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
        stop2      = 1'($urandom);
        for (int i = 0; i < nb; i++) run_ticks(dm[i], OS);
        if (pen) run_ticks((^dm) ^ podd ^ bad_par, OS);
        run_ticks(!bad_stop[0], OS);
        if (s2) run_ticks(!bad_stop[1], OS);
        check("busy_after_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0] r_len, r_bs;
        logic       r_pen, r_odd, r_s2, r_bp, final_low;
        logic [7:0] r_d;
        int         done_before;

        rst        = 1'b1;
        rx         = 1'b1;
        rx_tick    = 1'b0;
        data_len   = 2'd3;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(rx_done), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        #1 rst = 1'b1;
        run_ticks(1'b1, 4);

        // 8N1 0xA5
        busy_hit = 1'b0;
        send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 2'b00);
        check("t1_data", 32'(rx_data), 32'hA5);
        check("t1_perr", 32'(parity_err), 32'd0);
        check("t1_ferr", 32'(frame_err), 32'd0);
        check("t1_busy_seen", 32'(busy_hit), 32'd1);
        run_ticks(1'b1, 3);

        // 7E1 0x35, good parity then flipped parity
        send_frame(2'd2, 1'b1, 1'b0, 1'b0, 8'h35, 1'b0, 2'b00);
        check("t2a_data", 32'(rx_data), 32'h35);
        check("t2a_perr", 32'(parity_err), 32'd0);
        send_frame(2'd2, 1'b1, 1'b0, 1'b0, 8'h35, 1'b1, 2'b00);
        check("t2b_data", 32'(rx_data), 32'h35);
        check("t2b_perr", 32'(parity_err), 32'd1);
        run_ticks(1'b1, 2);

        // Short start glitch
        busy_hit    = 1'b0;
        done_before = n_done;
        run_ticks(1'b0, 4);
        run_ticks(1'b1, 2 * OS);
        check("t3_no_done", 32'(n_done - done_before), 32'd0);
        check("t3_busy_never", 32'(busy_hit), 32'd0);

        // 8N2 with second stop low, then line held low three bit times
        done_before = n_done;
        send_frame(2'd3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 2'b10);
        check("t4_ferr", 32'(frame_err), 32'd1);
        check("t4_data", 32'(rx_data), 32'hC3);
        run_ticks(1'b0, 3 * OS);
        check("t4_one_done", 32'(n_done - done_before), 32'd1);
        run_ticks(1'b1, OS);
        send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 2'b00);
        check("t4_recover", 32'(rx_data), 32'h5A);
        check("t4_ferr_clear", 32'(frame_err), 32'd0);

        // 5O1 back-to-back with no idle gap
        done_before = n_done;
        send_frame(2'd0, 1'b1, 1'b1, 1'b0, 8'h1F, 1'b0, 2'b00);
        check("t5a_data", 32'(rx_data), 32'h1F);
        send_frame(2'd0, 1'b1, 1'b1, 1'b0, 8'h0A, 1'b0, 2'b00);
        check("t5b_data", 32'(rx_data), 32'h0A);
        check("t5_two_done", 32'(n_done - done_before), 32'd2);

        // Reset mid-DATA aborts the frame
        data_len  = 2'd3;
        parity_en = 1'b0;
        stop2     = 1'b0;
        run_ticks(1'b0, OS);
        run_ticks(1'b1, OS);
        run_ticks(1'b0, OS / 2 + 3);
        done_before = n_done;
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        check("t6_reset_data", 32'(rx_data), 32'd0);
        check("t6_reset_busy", 32'(busy), 32'd0);
        #1 rst = 1'b1;
        run_ticks(1'b1, 4);
        send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 2'b00);
        check("t6_data", 32'(rx_data), 32'h3C);
        check("t6_one_done", 32'(n_done - done_before), 32'd1);

        // Randomised frames with random format, corruption and idle gaps
        for (int f = 0; f < 24; f++) begin
            r_len = 2'($urandom);
            r_pen = 1'($urandom);
            r_odd = 1'($urandom);
            r_s2  = 1'($urandom);
            r_d   = 8'($urandom);
            r_bp  = ($urandom_range(0, 3) == 0);
            r_bs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (!r_s2) r_bs[1] = 1'b0;
            final_low = r_s2 ? r_bs[1] : r_bs[0];
            send_frame(r_len, r_pen, r_odd, r_s2, r_d, r_bp, r_bs);
            run_ticks(1'b1, final_low ? $urandom_range(1, 4) : $urandom_range(0, 3));
        end
        run_ticks(1'b1, 4);

        check("all_frames_delivered", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
